// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and sizing helpers for the Fibonacci engine
package fib_pkg;

   typedef enum logic {IDLE, RUN} fib_state_t;

   // Number of beats needed to carry cnt terms at lanes terms per beat.
   function automatic int unsigned beats(input int unsigned cnt, input int unsigned lanes);
      return (cnt + lanes - 1) / lanes;
   endfunction

   // Number of populated lanes in the final beat of a cnt-term run.
   function automatic int unsigned last_lanes(input int unsigned cnt, input int unsigned lanes);
      return (cnt + lanes - 1) % lanes + 1;
   endfunction

endpackage

// File: rtl/fib_lane_chain.sv
// rtl/fib_lane_chain.sv - combinational chain producing LANES+2 consecutive terms
module fib_lane_chain #(
   parameter int WIDTH = 16,
   parameter int LANES = 2
) (
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   output logic [(LANES+2)*WIDTH-1:0]   terms,
   output logic [LANES+1:0]             carry
);

   // Term j is the wrapped sum of terms j-1 and j-2; carry[j] records the lost bit.
   // Terms 0 and 1 are the inputs themselves, so their carry bits are always 0.
   always_comb begin
      terms = '0;
      carry = '0;
      terms[0 +: WIDTH]     = a;
      terms[WIDTH +: WIDTH] = b;
      for (int j = 2; j < LANES + 2; j++) begin
         {carry[j], terms[j*WIDTH +: WIDTH]} = {1'b0, terms[(j-1)*WIDTH +: WIDTH]}
                                             + {1'b0, terms[(j-2)*WIDTH +: WIDTH]};
      end
   end

endmodule

// File: rtl/fibonacci_multi_rate.sv
// rtl/fibonacci_multi_rate.sv - multi-lane Fibonacci stream source with backpressure
module fibonacci_multi_rate
   import fib_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LANES = 2,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [WIDTH-1:0]         seed0,
   input  logic [WIDTH-1:0]         seed1,
   input  logic [CNT_W-1:0]         count,
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*WIDTH-1:0]   out_num,
   output logic [LANES-1:0]         out_mask,
   output logic                     out_last,
   output logic                     overflow,
   output logic                     done
);

   fib_state_t                 state, state_nx;
   logic [WIDTH-1:0]           a, b;
   logic                       ca, cb;
   logic [CNT_W-1:0]           beats_left;
   logic [LANES-1:0]           last_mask, start_mask, cur_mask;
   logic                       ovf_q, done_q;
   logic [(LANES+2)*WIDTH-1:0] terms;
   logic [LANES+1:0]           carry, cv;
   logic                       accept, hs, beat_ovf;
   int unsigned                start_lanes;

   fib_lane_chain #(.WIDTH(WIDTH), .LANES(LANES)) u_chain (
      .a     (a),
      .b     (b),
      .terms (terms),
      .carry (carry)
   );

   assign accept    = (state == IDLE) && start;
   assign out_valid = (state == RUN);
   assign busy      = (state == RUN);
   assign out_last  = out_valid && (beats_left == CNT_W'(1));
   assign cur_mask  = out_last ? last_mask : '1;
   assign out_mask  = out_valid ? cur_mask : '0;
   assign out_num   = out_valid ? terms[LANES*WIDTH-1:0] : '0;
   assign hs        = out_valid && out_ready;
   // a and b were themselves produced by additions on the previous beat, so their
   // carries travel with them; seeds load with clear carries and never flag.
   assign cv        = carry | {{LANES{1'b0}}, cb, ca};
   assign beat_ovf  = |(cv[LANES-1:0] & out_mask);
   assign overflow  = ovf_q | beat_ovf;
   assign done      = done_q;

   // Lane-valid pattern for the final beat of the run being launched.
   always_comb begin
      start_lanes = last_lanes(32'(count), 32'(LANES));
      start_mask  = '0;
      for (int i = 0; i < LANES; i++) begin
         if (32'(i) < start_lanes) start_mask[i] = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state: launch only with a nonzero count, return after the last beat handshakes.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start && count != '0) state_nx = RUN;
         RUN:     if (hs && out_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: seed on launch, advance by LANES terms per handshake, track overflow and done.
   always_ff @(posedge clk) begin
      if (rst) begin
         a          <= '0;
         b          <= '0;
         ca         <= 1'b0;
         cb         <= 1'b0;
         beats_left <= '0;
         last_mask  <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            a          <= seed0;
            b          <= seed1;
            ca         <= 1'b0;
            cb         <= 1'b0;
            beats_left <= CNT_W'(beats(32'(count), 32'(LANES)));
            last_mask  <= start_mask;
            ovf_q      <= 1'b0;
            if (count == '0) done_q <= 1'b1;
         end else if (hs) begin
            a          <= terms[LANES*WIDTH +: WIDTH];
            b          <= terms[(LANES+1)*WIDTH +: WIDTH];
            ca         <= cv[LANES];
            cb         <= cv[LANES+1];
            beats_left <= beats_left - CNT_W'(1);
            ovf_q      <= ovf_q | beat_ovf;
            if (out_last) done_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fibonacci_multi_rate.sv
// tb/tb_fibonacci_multi_rate.sv - directed self-checking bench for fibonacci_multi_rate
module tb_fibonacci_multi_rate;

   logic        clk = 1'b0;
   logic        rst;
   logic        start1, start2, start3;
   logic [15:0] seed0, seed1, count;
   logic        ready;

   logic        busy2, valid2, last2, ovf2, done2;
   logic [31:0] num2;
   logic [1:0]  mask2;
   logic        busy3, valid3, last3, ovf3, done3;
   logic [47:0] num3;
   logic [2:0]  mask3;
   logic        busy1, valid1, last1, ovf1, done1;
   logic [15:0] num1;
   logic [0:0]  mask1;

   int checks = 0;
   int errors = 0;
   logic [15:0] seq1 [10];

   always #5 clk = ~clk;

   fibonacci_multi_rate #(.WIDTH(16), .LANES(2), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst), .start(start2), .seed0(seed0), .seed1(seed1), .count(count),
      .busy(busy2), .out_valid(valid2), .out_ready(ready), .out_num(num2), .out_mask(mask2),
      .out_last(last2), .overflow(ovf2), .done(done2));

   fibonacci_multi_rate #(.WIDTH(16), .LANES(3), .CNT_W(16)) u3 (
      .clk(clk), .rst(rst), .start(start3), .seed0(seed0), .seed1(seed1), .count(count),
      .busy(busy3), .out_valid(valid3), .out_ready(ready), .out_num(num3), .out_mask(mask3),
      .out_last(last3), .overflow(ovf3), .done(done3));

   fibonacci_multi_rate #(.WIDTH(16), .LANES(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .start(start1), .seed0(seed0), .seed1(seed1), .count(count),
      .busy(busy1), .out_valid(valid1), .out_ready(ready), .out_num(num1), .out_mask(mask1),
      .out_last(last1), .overflow(ovf1), .done(done1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      seq1 = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34, 16'd55};
      rst = 1'b1; start1 = 0; start2 = 0; start3 = 0;
      seed0 = 0; seed1 = 0; count = 0; ready = 1'b1;
      tick(); tick();
      chk("rst_valid", valid2, 0); chk("rst_num", num2, 0); chk("rst_mask", mask2, 0);
      chk("rst_last", last2, 0); chk("rst_ovf", ovf2, 0); chk("rst_done", done2, 0);
      chk("rst_busy", busy2, 0);
      rst = 1'b0;
      tick();

      // LANES=2, seeds 1,1, count 7
      seed0 = 1; seed1 = 1; count = 7; start2 = 1;
      tick(); start2 = 0;
      chk("l2_b0_valid", valid2, 1); chk("l2_b0_num", num2, 32'h0001_0001);
      chk("l2_b0_mask", mask2, 2'b11); chk("l2_b0_last", last2, 0); chk("l2_busy", busy2, 1);
      tick(); chk("l2_b1_num", num2, 32'h0003_0002);
      tick(); chk("l2_b2_num", num2, 32'h0008_0005);
      tick(); chk("l2_b3_lane0", num2[15:0], 16'd13); chk("l2_b3_mask", mask2, 2'b01);
      chk("l2_b3_last", last2, 1);
      tick(); chk("l2_done", done2, 1); chk("l2_idle_valid", valid2, 0);
      tick(); chk("l2_done_pulse", done2, 0);

      // start during RUN is ignored
      seed0 = 1; seed1 = 1; count = 5; start2 = 1;
      tick(); chk("ign_b0_num", num2, 32'h0001_0001);
      seed0 = 7; seed1 = 9;
      tick(); chk("ign_b1_num", num2, 32'h0003_0002);
      start2 = 0;
      tick(); chk("ign_b2_lane0", num2[15:0], 16'd5); chk("ign_b2_last", last2, 1);
      chk("ign_b2_mask", mask2, 2'b01);
      tick(); chk("ign_done", done2, 1);

      // count 0: no beats, done next cycle
      count = 0; start2 = 1;
      tick(); start2 = 0;
      chk("c0_valid", valid2, 0); chk("c0_done", done2, 1); chk("c0_busy", busy2, 0);
      tick(); chk("c0_done_pulse", done2, 0);

      // overflow on F(24) with count 25
      seed0 = 1; seed1 = 1; count = 25; start2 = 1;
      tick(); start2 = 0;
      for (int k = 1; k <= 11; k++) tick();
      chk("ov_b11_num", num2, 32'hB520_6FF1); chk("ov_b11_ovf", ovf2, 0);
      tick(); chk("ov_b12_lane0", num2[15:0], 16'd9489); chk("ov_b12_ovf", ovf2, 1);
      chk("ov_b12_last", last2, 1); chk("ov_b12_mask", mask2, 2'b01);
      tick(); chk("ov_sticky", ovf2, 1); chk("ov_done", done2, 1);
      count = 24; start2 = 1;
      tick(); start2 = 0;
      chk("ov_cleared", ovf2, 0);
      for (int k = 1; k <= 11; k++) tick();
      chk("c24_last_num", num2, 32'hB520_6FF1); chk("c24_last", last2, 1);
      chk("c24_mask", mask2, 2'b11); chk("c24_ovf", ovf2, 0);
      tick(); chk("c24_done", done2, 1); chk("c24_ovf_after", ovf2, 0);

      // reset mid-run at beat 2 of 5
      seed0 = 1; seed1 = 1; count = 10; start2 = 1;
      tick(); start2 = 0;
      tick(); tick(); chk("mr_b2_num", num2, 32'h0008_0005);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("mr_valid", valid2, 0); chk("mr_num", num2, 0); chk("mr_mask", mask2, 0);
      chk("mr_last", last2, 0); chk("mr_busy", busy2, 0); chk("mr_done", done2, 0);
      chk("mr_ovf", ovf2, 0);
      start2 = 1;
      tick(); start2 = 0;
      chk("mr_restart_num", num2, 32'h0001_0001); chk("mr_restart_valid", valid2, 1);
      for (int k = 1; k <= 4; k++) tick();
      chk("mr_restart_last", last2, 1); chk("mr_restart_lastnum", num2, 32'h0037_0022);
      tick(); chk("mr_restart_done", done2, 1);

      // LANES=3 with backpressure on beat 0
      seed0 = 0; seed1 = 1; count = 6; ready = 0; start3 = 1;
      tick(); start3 = 0;
      chk("l3_b0_num", num3, 48'h0001_0001_0000); chk("l3_b0_last", last3, 0);
      tick(); chk("l3_hold1_num", num3, 48'h0001_0001_0000); chk("l3_hold1_mask", mask3, 3'b111);
      tick(); chk("l3_hold2_num", num3, 48'h0001_0001_0000); chk("l3_hold2_last", last3, 0);
      ready = 1;
      tick(); chk("l3_b1_num", num3, 48'h0005_0003_0002); chk("l3_b1_last", last3, 1);
      chk("l3_b1_mask", mask3, 3'b111);
      tick(); chk("l3_done", done3, 1); chk("l3_idle", valid3, 0);

      // LANES=1, seeds 1,1, count 10
      seed0 = 1; seed1 = 1; count = 10; start1 = 1;
      tick(); start1 = 0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("l1_num%0d", i), num1, seq1[i]);
         chk($sformatf("l1_last%0d", i), last1, (i == 9) ? 1'b1 : 1'b0);
         tick();
      end
      chk("l1_done", done1, 1); chk("l1_valid_end", valid1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
